// File: rtl/mult_div_unit.sv
// Iterative MIPS-style HI/LO multiply/divide unit: one shift-add or restoring
// shift-subtract step per cycle through a single shared adder, W steps per operation.
module mult_div_unit #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         hi_we,
  input  logic         lo_we,
  input  logic [W-1:0] wdata,
  output logic         busy,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo,
  output logic         dbg_state
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt;
  logic           is_div, is_uns, sa, sb;
  logic [W-1:0]   a_raw, dvs, acc, q;

  logic           a_neg, b_neg;
  logic [W-1:0]   mag_a, mag_b;
  logic [W+1:0]   add_a, add_b, sum;
  logic           cin, nb, last;
  logic [W-1:0]   acc_n, q_n, quot, rmd, hi_fin, lo_fin;
  logic [2*W-1:0] prod;

  // Signed ops run on magnitudes; the signs are reapplied on the final step.
  assign a_neg = ~op[0] & A[W-1];
  assign b_neg = ~op[0] & B[W-1];
  assign mag_a = a_neg ? (~A + 1'b1) : A;
  assign mag_b = b_neg ? (~B + 1'b1) : B;
  assign last  = (cnt == LAST);

  // Shared adder: multiply adds the multiplicand into the high half; divide
  // subtracts the divisor from {remainder, next dividend bit}, sign bit = borrow.
  always_comb begin
    if (is_div) begin
      add_a = {1'b0, acc, q[W-1]};
      add_b = ~{2'b00, dvs};
      cin   = 1'b1;
    end else begin
      add_a = {2'b00, acc};
      add_b = q[0] ? {2'b00, dvs} : '0;
      cin   = 1'b0;
    end
    sum = add_a + add_b + {{(W+1){1'b0}}, cin};
    nb  = ~sum[W+1];
    if (is_div) begin
      acc_n = nb ? sum[W-1:0] : {acc[W-2:0], q[W-1]};
      q_n   = {q[W-2:0], nb};
    end else begin
      acc_n = sum[W:1];
      q_n   = {sum[0], q[W-1:1]};
    end
  end

  always_comb begin
    prod = {acc_n, q_n};
    if (!is_uns && (sa ^ sb)) prod = ~prod + 1'b1;
    quot = (!is_uns && (sa ^ sb)) ? (~q_n + 1'b1) : q_n;
    rmd  = (!is_uns && sa) ? (~acc_n + 1'b1) : acc_n;
    if (!is_div) begin
      hi_fin = prod[2*W-1:W];
      lo_fin = prod[W-1:0];
    end else if (dvs == '0) begin
      hi_fin = a_raw;
      lo_fin = '1;
    end else begin
      hi_fin = rmd;
      lo_fin = quot;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN:  if (last)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      busy    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      cnt     <= '0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d == RUN);
      case (state_q)
        IDLE: begin
          if (start) begin
            is_div <= op[1];
            is_uns <= op[0];
            sa     <= a_neg;
            sb     <= b_neg;
            a_raw  <= A;
            dvs    <= mag_b;
            acc    <= '0;
            q      <= mag_a;
            cnt    <= '0;
          end else begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
          end
        end
        RUN: begin
          acc <= acc_n;
          q   <= q_n;
          cnt <= cnt + 1'b1;
          if (last) begin
            hi <= hi_fin;
            lo <= lo_fin;
          end
        end
        default: ;
      endcase
    end
  end

  assign dbg_state = state_q;

endmodule
